// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences a WIDTH-bit up/down counter: load on Start, count in RUN,
//   freeze in HOLD, detect the terminal value, then either finish with a
//   one-cycle DONE (one-shot) or reload and keep running (auto-reload).
//
//   Optional build macro: COUNTER_SEQUENCER_PRESCALE_EN
//     defined   -> one count tick every PRESCALE clocks while in RUN
//     undefined -> one count tick on every RUN clock
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Start      in   begin a sequence (sampled only in IDLE)
//   Abort      in   cancel a sequence in RUN/HOLD/DONE, return to IDLE
//   Hold       in   freeze counting while high
//   Up         in   direction, 1 = up / 0 = down (captured on Start)
//   AutoReload in   1 = periodic, 0 = one-shot (captured on Start)
//   LoadVal    in   start/reload value (captured on Start)
//   Count      out  current count, registered
//   Busy       out  high in RUN and HOLD
//   Done       out  one-cycle pulse on one-shot completion
//   Wrap       out  one-cycle pulse on each auto-reload
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Hold,
  input  logic             Up,
  input  logic             AutoReload,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Wrap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  if (PRESCALE < 2) begin : g_prescale_check
    $error("counter_sequencer: PRESCALE must be at least 2");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_up;
  logic             r_auto;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic [1:0]       w_state_n;
  logic [WIDTH-1:0] w_count_n;
  logic [WIDTH-1:0] w_reload_n;
  logic             w_up_n;
  logic             w_auto_n;
  logic             w_wrap_n;
  logic             w_tick;
  logic             w_at_term;

  assign w_at_term = r_up ? (r_count == ALL_ONES) : (r_count == '0);

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  assign w_tick = (r_pre == PRE_LAST);

  // Phase is cleared outside RUN/HOLD (covers Start) and on Abort, and
  // only advances on RUN cycles that are not being held.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pre <= '0;
    end else if (Abort || (r_state == S_IDLE) || (r_state == S_DONE)) begin
      r_pre <= '0;
    end else if ((r_state == S_RUN) && !Hold) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_state_n  = r_state;
    w_count_n  = r_count;
    w_reload_n = r_reload;
    w_up_n     = r_up;
    w_auto_n   = r_auto;
    w_wrap_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Start outranks a simultaneous Abort here; Abort alone does nothing.
        if (Start) begin
          w_state_n  = S_RUN;
          w_count_n  = LoadVal;
          w_reload_n = LoadVal;
          w_up_n     = Up;
          w_auto_n   = AutoReload;
        end
      end
      S_RUN: begin
        if (Abort) begin
          w_state_n = S_IDLE;
          w_count_n = '0;
        end else if (Hold) begin
          w_state_n = S_HOLD;
        end else if (w_tick) begin
          if (!w_at_term) begin
            w_count_n = r_up ? r_count + 1'b1 : r_count - 1'b1;
          end else if (r_auto) begin
            w_count_n = r_reload;
            w_wrap_n  = 1'b1;
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_HOLD: begin
        if (Abort) begin
          w_state_n = S_IDLE;
          w_count_n = '0;
        end else if (!Hold) begin
          w_state_n = S_RUN;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        if (Abort) begin
          w_count_n = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_count_n = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_up     <= 1'b0;
      r_auto   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_count  <= w_count_n;
      r_reload <= w_reload_n;
      r_up     <= w_up_n;
      r_auto   <= w_auto_n;
      r_busy   <= (w_state_n == S_RUN) || (w_state_n == S_HOLD);
      r_done   <= (w_state_n == S_DONE);
      r_wrap   <= w_wrap_n;
    end
  end

  assign Count = r_count;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Wrap  = r_wrap;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (default build, no prescaler).
module tb_counter_sequencer;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic             Abort;
  logic             Hold;
  logic             Up;
  logic             AutoReload;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Count;
  logic             Busy;
  logic             Done;
  logic             Wrap;

  int errors = 0;
  int checks = 0;

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Abort      (Abort),
    .Hold       (Hold),
    .Up         (Up),
    .AutoReload (AutoReload),
    .LoadVal    (LoadVal),
    .Count      (Count),
    .Busy       (Busy),
    .Done       (Done),
    .Wrap       (Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] c,
                     input logic b, input logic d, input logic w);
    checks++;
    assert (Count === c) else begin
      errors++;
      $error("FAIL %s.count observed=%0d expected=%0d", tag, Count, c);
    end
    checks++;
    assert (Busy === b) else begin
      errors++;
      $error("FAIL %s.busy observed=%0b expected=%0b", tag, Busy, b);
    end
    checks++;
    assert (Done === d) else begin
      errors++;
      $error("FAIL %s.done observed=%0b expected=%0b", tag, Done, d);
    end
    checks++;
    assert (Wrap === w) else begin
      errors++;
      $error("FAIL %s.wrap observed=%0b expected=%0b", tag, Wrap, w);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Hold = 1'b0;
    Up = 1'b0; AutoReload = 1'b0; LoadVal = '0;
    tick(); tick();
    chk("reset", 0, 0, 0, 0);
    Reset = 1'b0;

    // One-shot up from 13; inputs changed after Start must not matter.
    Up = 1'b1; AutoReload = 1'b0; LoadVal = 4'd13; Start = 1'b1;
    tick(); chk("os_load", 13, 1, 0, 0);
    Start = 1'b0; Up = 1'b0; AutoReload = 1'b1; LoadVal = 4'd0;
    tick(); chk("os_14", 14, 1, 0, 0);
    tick(); chk("os_15", 15, 1, 0, 0);
    tick(); chk("os_done", 15, 0, 1, 0);
    Start = 1'b1; LoadVal = 4'd3;          // ignored during DONE
    tick(); chk("os_idle", 15, 0, 0, 0);
    Start = 1'b0; Abort = 1'b1;            // no effect in IDLE
    tick(); chk("idle_abort", 15, 0, 0, 0);

    // Start and Abort together in IDLE: Start wins; then Abort in RUN.
    Start = 1'b1; Up = 1'b1; AutoReload = 1'b0; LoadVal = 4'd5;
    tick(); chk("start_abort", 5, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("run_abort", 0, 0, 0, 0);
    Abort = 1'b0;

    // Auto-reload down from 2.
    Up = 1'b0; AutoReload = 1'b1; LoadVal = 4'd2; Start = 1'b1;
    tick(); chk("ar_load", 2, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("ar_1a", 1, 1, 0, 0);
    tick(); chk("ar_0a", 0, 1, 0, 0);
    tick(); chk("ar_wrap1", 2, 1, 0, 1);
    tick(); chk("ar_1b", 1, 1, 0, 0);
    tick(); chk("ar_0b", 0, 1, 0, 0);
    tick(); chk("ar_wrap2", 2, 1, 0, 1);
    Abort = 1'b1;
    tick(); chk("ar_abort", 0, 0, 0, 0);
    Abort = 1'b0;

    // Auto-reload up wraps at all-ones.
    Up = 1'b1; AutoReload = 1'b1; LoadVal = 4'd14; Start = 1'b1;
    tick(); chk("aru_load", 14, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("aru_15", 15, 1, 0, 0);
    tick(); chk("aru_wrap", 14, 1, 0, 1);
    Abort = 1'b1;
    tick(); chk("aru_abort", 0, 0, 0, 0);
    Abort = 1'b0;

    // Hold for three cycles at 5, resume, run to completion.
    Up = 1'b1; AutoReload = 1'b0; LoadVal = 4'd3; Start = 1'b1;
    tick(); chk("h_load", 3, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("h_4", 4, 1, 0, 0);
    tick(); chk("h_5", 5, 1, 0, 0);
    Hold = 1'b1;
    tick(); chk("h_hold1", 5, 1, 0, 0);
    tick(); chk("h_hold2", 5, 1, 0, 0);
    tick(); chk("h_hold3", 5, 1, 0, 0);
    Hold = 1'b0;
    tick(); chk("h_release", 5, 1, 0, 0);
    for (int v = 6; v <= 15; v++) begin
      tick(); chk("h_run", WIDTH'(v), 1, 0, 0);
    end
    tick(); chk("h_done", 15, 0, 1, 0);
    tick(); chk("h_idle", 15, 0, 0, 0);

    // Start while RUN is ignored; Abort at 9.
    LoadVal = 4'd7; Start = 1'b1;
    tick(); chk("rs_load", 7, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("rs_8", 8, 1, 0, 0);
    Start = 1'b1; LoadVal = 4'd1;
    tick(); chk("rs_ignored", 9, 1, 0, 0);
    Start = 1'b0; Abort = 1'b1;
    tick(); chk("rs_abort", 0, 0, 0, 0);
    Abort = 1'b0;

    // Abort from HOLD.
    LoadVal = 4'd4; Start = 1'b1;
    tick(); chk("ha_load", 4, 1, 0, 0);
    Start = 1'b0; Hold = 1'b1;
    tick(); chk("ha_hold", 4, 1, 0, 0);
    Abort = 1'b1;
    tick(); chk("ha_abort", 0, 0, 0, 0);
    Abort = 1'b0; Hold = 1'b0;

    // Abort from DONE suppresses nothing further and clears Count.
    LoadVal = 4'd15; Start = 1'b1;
    tick(); chk("da_load", 15, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("da_done", 15, 0, 1, 0);
    Abort = 1'b1;
    tick(); chk("da_abort", 0, 0, 0, 0);
    Abort = 1'b0;

    // Reset mid-run at 7, then one-shot starting at terminal.
    LoadVal = 4'd5; Start = 1'b1;
    tick(); chk("rr_load", 5, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("rr_6", 6, 1, 0, 0);
    tick(); chk("rr_7", 7, 1, 0, 0);
    Reset = 1'b1;
    tick(); chk("rr_reset", 0, 0, 0, 0);
    Reset = 1'b0;
    Up = 1'b1; AutoReload = 1'b0; LoadVal = 4'd15; Start = 1'b1;
    tick(); chk("term_load", 15, 1, 0, 0);
    Start = 1'b0;
    tick(); chk("term_done", 15, 0, 1, 0);
    tick(); chk("term_idle", 15, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
